// File: rtl/gfx_defs.sv
// Shared graphics definitions: default vector geometry, register index and
// lane/vector types used by the vector register file and its clients.
package gfx_defs;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 32;
  localparam int DEF_REGS   = 16;
  localparam int DEF_VREG_W = $clog2(DEF_REGS);

  typedef logic [DEF_VREG_W-1:0] vreg_num;
  typedef logic [DEF_LANE_W-1:0] lane_t;
  typedef lane_t [DEF_LANES-1:0] vec_t;
  typedef logic [DEF_LANES-1:0]  lane_mask_t;

endpackage

// File: rtl/gfx_sp_file_rd_port.sv
// One read port of the vector register file: index stage, array/bypass
// stage and output stage. Fixed three-edge latency, never stalls.
// Optional build macro GFX_SP_FILE_BYPASS_EN forwards the staged write into
// the array stage so a write and read sampled on the same edge agree.
module gfx_sp_file_rd_port
  import gfx_defs::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int IDX_W  = DEF_VREG_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [IDX_W-1:0]             idx,
  output logic [IDX_W-1:0]             arr_idx,
  input  logic [LANES-1:0][LANE_W-1:0] arr_word,
`ifdef GFX_SP_FILE_BYPASS_EN
  input  logic                         fwd_valid,
  input  logic [IDX_W-1:0]             fwd_reg,
  input  logic [LANES-1:0]             fwd_mask,
  input  logic [LANES-1:0][LANE_W-1:0] fwd_data,
`endif
  output logic                         valid,
  output logic [LANES-1:0][LANE_W-1:0] data
);

  logic                         s1_valid;
  logic [IDX_W-1:0]             s1_idx;
  logic                         s2_valid;
  logic [LANES-1:0][LANE_W-1:0] s2_data;
  logic [LANES-1:0][LANE_W-1:0] word;

  // The array is read combinationally in the top using the index-stage value.
  assign arr_idx = s1_idx;

  // Index stage: capture the request.
  // NOTE: sequential state uses <= so every stage sees the pre-edge value of
  // the stage before it; blocking = here would collapse the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= en;
      s1_idx   <= idx;
    end
  end

  // Array stage word selection, with per-lane forwarding of the staged write.
  always_comb begin
    // NOTE: default assignment first so no path leaves word unassigned
    // (which would infer a latch).
    word = arr_word;
`ifdef GFX_SP_FILE_BYPASS_EN
    if (fwd_valid && (fwd_reg == s1_idx)) begin
      for (int l = 0; l < LANES; l++) begin
        if (fwd_mask[l]) word[l] = fwd_data[l];
      end
    end
`endif
  end

  // Array stage: register the selected word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_data  <= word;
    end
  end

  // Output stage: result holds its last value whenever no read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= s2_valid;
      if (s2_valid) data <= s2_data;
    end
  end

endmodule

// File: rtl/gfx_sp_file_mp.sv
// Multi-port vector register file: REGS registers of LANES x LANE_W bits,
// READ_PORTS independent three-stage read pipelines and one staged,
// lane-masked write port.
// Optional build macro GFX_SP_FILE_BYPASS_EN enables same-edge write-to-read
// forwarding in every read port; latency is unchanged either way.
module gfx_sp_file_mp
  import gfx_defs::*;
#(
  parameter int READ_PORTS = 2,
  parameter int LANES      = DEF_LANES,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int REGS       = DEF_REGS
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [READ_PORTS-1:0]                         rd_en,
  input  logic [READ_PORTS-1:0][$clog2(REGS)-1:0]       rd_reg,
  output logic [READ_PORTS-1:0]                         rd_valid,
  output logic [READ_PORTS-1:0][LANES-1:0][LANE_W-1:0]  rd_data,
  input  logic                                          wr,
  input  logic [$clog2(REGS)-1:0]                       wr_reg,
  input  logic [LANES-1:0]                              wr_mask,
  input  logic [LANES-1:0][LANE_W-1:0]                  wr_data
);

  localparam int IDX_W = $clog2(REGS);

  // Staged write: sampled on edge W, committed to the array on edge W+1.
  logic                         w_valid;
  logic [IDX_W-1:0]             w_reg;
  logic [LANES-1:0]             w_mask;
  logic [LANES-1:0][LANE_W-1:0] w_data;

  logic [LANES-1:0][LANE_W-1:0] mem [REGS];

  // Write staging register; a reset drops any uncommitted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_reg   <= '0;
      w_mask  <= '0;
      w_data  <= '0;
    end else begin
      w_valid <= wr;
      w_reg   <= wr_reg;
      w_mask  <= wr_mask;
      w_data  <= wr_data;
    end
  end

  // Array commit: only masked lanes of the staged write change.
  // NOTE: the storage array has no reset so it maps onto RAM/flop arrays
  // without a reset tree; contents are undefined until written.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_valid && w_mask[l]) mem[w_reg][l] <= w_data[l];
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [IDX_W-1:0]             arr_idx;
    logic [LANES-1:0][LANE_W-1:0] arr_word;

    // Array read for this port at its index stage.
    assign arr_word = mem[arr_idx];

    gfx_sp_file_rd_port #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .IDX_W  (IDX_W)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (rd_en[p]),
      .idx       (rd_reg[p]),
      .arr_idx   (arr_idx),
      .arr_word  (arr_word),
`ifdef GFX_SP_FILE_BYPASS_EN
      .fwd_valid (w_valid),
      .fwd_reg   (w_reg),
      .fwd_mask  (w_mask),
      .fwd_data  (w_data),
`endif
      .valid     (rd_valid[p]),
      .data      (rd_data[p])
    );
  end

endmodule

// File: tb/tb_gfx_sp_file_mp.sv
// Directed self-checking bench for gfx_sp_file_mp (default geometry,
// two read ports). Expectations follow GFX_SP_FILE_BYPASS_EN when defined.
module tb_gfx_sp_file_mp;
  import gfx_defs::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           rd_en;
  logic [1:0][3:0]      rd_reg;
  logic [1:0]           rd_valid;
  logic [1:0][127:0]    rd_data;
  logic                 wr;
  logic [3:0]           wr_reg;
  logic [3:0]           wr_mask;
  logic [127:0]         wr_data;

  int n_vec = 0;
  int n_err = 0;

  gfx_sp_file_mp #(
    .READ_PORTS (2),
    .LANES      (4),
    .LANE_W     (32),
    .REGS       (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_reg   (rd_reg),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr       (wr),
    .wr_reg   (wr_reg),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t v4(input int a, input int b, input int c, input int d);
    return {a[31:0], b[31:0], c[31:0], d[31:0]};
  endfunction

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int r, input logic [3:0] m, input vec_t d);
    wr = 1'b1; wr_reg = r[3:0]; wr_mask = m; wr_data = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic read_check(input string tag, input int p, input int r, input vec_t exp);
    rd_en[p] = 1'b1; rd_reg[p] = r[3:0];
    tick();
    rd_en[p] = 1'b0;
    check({tag, "_lat1"}, rd_valid[p], 1'b0);
    tick();
    check({tag, "_lat2"}, rd_valid[p], 1'b0);
    tick();
    check({tag, "_valid"}, rd_valid[p], 1'b1);
    check({tag, "_data"}, rd_data[p], exp);
    tick();
    check({tag, "_pulse"}, rd_valid[p], 1'b0);
    check({tag, "_hold"}, rd_data[p], exp);
  endtask

  initial begin
    vec_t r2_old, r2_new, r9_val, r7_same;
    rst_n = 1'b0; rd_en = '0; rd_reg = '0; wr = 1'b0; wr_reg = '0; wr_mask = '0; wr_data = '0;
    tick();
    tick();
    check("rst_valid", rd_valid, 2'b00);
    check("rst_data", rd_data, 256'h0);
    rst_n = 1'b1;

    // Write accepted on the first edge after release, read after 2 idle cycles.
    do_write(3, 4'b1111, v4(4, 3, 2, 1));
    tick(); tick();
    read_check("r3_basic", 0, 3, v4(4, 3, 2, 1));
    check("r3_p1_idle", rd_valid[1], 1'b0);

    // Partial lane mask.
    do_write(5, 4'b1111, v4(32'hA, 32'hB, 32'hC, 32'hD));
    do_write(5, 4'b0101, v4(1, 2, 3, 4));
    tick(); tick();
    read_check("r5_mask", 1, 5, v4(32'hA, 2, 32'hC, 4));

    // All-zero mask leaves the register alone.
    do_write(5, 4'b0000, v4(32'hFF, 32'hFF, 32'hFF, 32'hFF));
    tick(); tick();
    read_check("r5_nomask", 0, 5, v4(32'hA, 2, 32'hC, 4));

    // Back-to-back writes, last writer wins per lane.
    do_write(1, 4'b1111, v4(1, 1, 1, 1));
    do_write(1, 4'b0011, v4(2, 2, 2, 2));
    tick(); tick();
    read_check("r1_b2b", 0, 1, v4(1, 1, 2, 2));

    // Same-edge write and read (R = W) on port 1, then R = W+1 on port 0.
    do_write(7, 4'b1111, v4(0, 0, 0, 0));
    tick(); tick();
`ifdef GFX_SP_FILE_BYPASS_EN
    r7_same = v4(9, 9, 9, 9);
`else
    r7_same = v4(0, 0, 0, 0);
`endif
    wr = 1'b1; wr_reg = 4'd7; wr_mask = 4'b1111; wr_data = v4(9, 9, 9, 9);
    rd_en = 2'b10; rd_reg[1] = 4'd7;
    tick();
    wr = 1'b0; rd_en = 2'b01; rd_reg[0] = 4'd7;
    tick();
    rd_en = 2'b00;
    tick();
    check("r7_same_valid", rd_valid, 2'b10);
    check("r7_same_data", rd_data[1], r7_same);
    tick();
    check("r7_next_valid", rd_valid, 2'b01);
    check("r7_next_data", rd_data[0], v4(9, 9, 9, 9));

    // Two ports, r2 being written while r9 is read alongside it.
    r2_old = v4(32'h20, 32'h21, 32'h22, 32'h23);
    r2_new = v4(32'h2a, 32'h2b, 32'h22, 32'h23);
    r9_val = v4(32'h90, 32'h91, 32'h92, 32'h93);
    do_write(2, 4'b1111, r2_old);
    do_write(9, 4'b1111, r9_val);
    tick(); tick();
    wr = 1'b1; wr_reg = 4'd2; wr_mask = 4'b1100; wr_data = v4(32'h2a, 32'h2b, 32'h2c, 32'h2d);
    rd_en = 2'b11; rd_reg[0] = 4'd2; rd_reg[1] = 4'd9;
    tick();
    wr = 1'b0; rd_reg[0] = 4'd9; rd_reg[1] = 4'd2;
    tick();
    rd_reg[0] = 4'd2; rd_reg[1] = 4'd2;
    tick();
    rd_en = 2'b00;
    check("mp0_valid", rd_valid, 2'b11);
`ifdef GFX_SP_FILE_BYPASS_EN
    check("mp0_p0_r2", rd_data[0], r2_new);
`else
    check("mp0_p0_r2", rd_data[0], r2_old);
`endif
    check("mp0_p1_r9", rd_data[1], r9_val);
    tick();
    check("mp1_p0_r9", rd_data[0], r9_val);
    check("mp1_p1_r2", rd_data[1], r2_new);
    tick();
    check("mp2_valid", rd_valid, 2'b11);
    check("mp2_p0_r2", rd_data[0], r2_new);
    check("mp2_p1_r2", rd_data[1], r2_new);
    tick();
    check("mp_idle", rd_valid, 2'b00);

    // Reset mid-flight: two reads in the pipe, a staged write to r3, a third
    // read presented during reset. None may surface and the write is lost.
    rd_en = 2'b01; rd_reg[0] = 4'd3;
    tick();
    rd_reg[0] = 4'd5;
    wr = 1'b1; wr_reg = 4'd3; wr_mask = 4'b1111; wr_data = v4(32'h77, 32'h77, 32'h77, 32'h77);
    tick();
    wr = 1'b0; rd_reg[0] = 4'd1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rd_valid, 2'b00);
    check("mid_rst_data", rd_data, 256'h0);
    tick();
    check("mid_rst_data2", rd_data, 256'h0);
    rst_n = 1'b1;
    rd_en = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst_quiet%0d", i), rd_valid, 2'b00);
    end
    read_check("r3_after_rst", 0, 3, v4(4, 3, 2, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
